// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Bit-serial subtractor. One full-subtractor cell and one borrow flop
//   produce d = a - b - bin_init (mod 2^WIDTH), one bit per clock, LSB first.
//   A start in IDLE latches the operands. WIDTH RUN cycles follow, then a
//   single DONE cycle, and the block returns to IDLE.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   request, sampled only in IDLE
//   a, b     in   WIDTH-bit minuend / subtrahend, latched on accepted start
//   bin_init in   initial borrow-in, latched on accepted start
//   busy     out  high in RUN and DONE
//   done     out  one-cycle pulse, results valid from this cycle on
//   d        out  WIDTH-bit difference, held until the next DONE or reset
//   bout     out  final borrow-out (1 when a < b + bin_init, unsigned)
//   ovf      out  signed overflow flag
//
// Build option
//   SERIAL_SUB_OVF_EN  when defined, ovf is captured from the sign bits at the
//                      last bit. When undefined, ovf is constant 0.

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10,
    BAD  = 2'b11
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa, sb, res, res_next, d_q;
  logic [CNTW-1:0]  cnt;
  logic             br, bout_q;
  logic             x, y, diff, borrow, last_bit;

  // The cell always looks at the current LSBs and the stored borrow.
  assign x        = sa[0];
  assign y        = sb[0];
  assign diff     = x ^ y ^ br;
  assign borrow   = (~x & y) | (~(x ^ y) & br);
  assign last_bit = (state == RUN) && (cnt == CNTW'(WIDTH - 1));

  // New difference bits enter at the MSB. After WIDTH shifts, bit 0 holds the
  // first (LSB) result.
  assign res_next = {diff, {(WIDTH-1){1'b0}}} | (res >> 1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == CNTW'(WIDTH - 1)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand shifters, borrow flop, bit counter and result registers.
  // The visible result loads directly from the final shift, so it changes
  // only at the RUN->DONE edge and never shows partial values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sa  <= a;
          sb  <= b;
          br  <= bin_init;
          cnt <= '0;
          res <= '0;
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_next;
          br  <= borrow;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            d_q    <= res_next;
            bout_q <= borrow;
          end
        end
        default: ;
      endcase
    end
  end

  assign d    = d_q;
  assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // At the last bit, x and y are the operand sign bits and diff is the result
  // MSB. Overflow occurs when the signs differ and the result sign differs
  // from the minuend sign.
  always_ff @(posedge clk) begin
    if (rst)           ovf_q <= 1'b0;
    else if (last_bit) ovf_q <= (x ^ y) & (x ^ diff);
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl
//   Testbench for serial_sub_ctrl (WIDTH=8). Each scenario task pushes the
//   expected result to a queue when it starts an operation. When done is
//   observed, the task pops the entry and compares it against the outputs.

module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk, rst, start, bin_init;
  logic [W-1:0] a, b;
  logic         busy, done, bout, ovf;
  logic [W-1:0] d;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin_init(bin_init),
    .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result: a 9-bit subtraction gives the borrow-out in bit 8.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbi);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbi};
    e.d    = full[W-1:0];
    e.bout = full[W];
`ifdef SERIAL_SUB_OVF_EN
    e.ovf  = (ma[W-1] ^ mb[W-1]) & (ma[W-1] ^ full[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  // Drive one accepted start. On return, time is 1 ns after the T0 edge. The
  // operands are then scrambled, because the block must not depend on them.
  task automatic start_op(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sbi);
    sb_q.push_back(model(sa, sb, sbi));
    a = sa; b = sb; bin_init = sbi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin_init = 1'($urandom);
  endtask

  // Step until done is seen, with a bounded budget. n counts cycles after T0.
  task automatic wait_done(output int n, output int busy_n, output bit seen);
    n = 1; busy_n = 0; seen = 1'b0;
    while (n <= 40) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h00; bin_init = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, d, bout, ovf} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b d=%h bout=%b ovf=%b, want all 0",
               busy, done, d, bout, ovf);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_priority: busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic;
    int n, bn; bit seen; exp_t e;
    start_op(8'h35, 8'h12, 1'b0);
    wait_done(n, bn, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || n != 9) begin
      errors++;
      $display("[TB] FAIL basic_latency: seen=%b n=%0d want done at 9", seen, n);
    end
    checks++;
    if (bn != 9) begin
      errors++;
      $display("[TB] FAIL basic_busy_cycles: got %0d want 9", bn);
    end
    checks++;
    if ({d, bout} !== {8'h23, 1'b0} || {d, bout, ovf} !== e) begin
      errors++;
      $display("[TB] FAIL basic_result: got d=%h bout=%b ovf=%b want d=%h bout=%b ovf=%b",
               d, bout, ovf, e.d, e.bout, e.ovf);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL basic_after_done: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_borrow_hold;
    int n, bn; bit seen; exp_t e; int bad;
    start_op(8'h00, 8'h01, 1'b0);
    wait_done(n, bn, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || {d, bout} !== 9'h1FF || {d, bout, ovf} !== e) begin
      errors++;
      $display("[TB] FAIL borrow_result: seen=%b got d=%h bout=%b want d=%h bout=%b",
               seen, d, bout, e.d, e.bout);
    end
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (d !== 8'hFF || bout !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL borrow_hold: %0d bad idle cycles, last d=%h bout=%b done=%b, want d=ff bout=1 done=0",
               bad, d, bout, done);
    end
  endtask

  task automatic test_back_to_back;
    int n, bn; bit seen; exp_t e;
    start_op(8'h10, 8'h0F, 1'b1);
    wait_done(n, bn, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || {d, bout} !== 9'h000 || {d, bout, ovf} !== e) begin
      errors++;
      $display("[TB] FAIL b2b_first: seen=%b got d=%h bout=%b want d=%h bout=%b",
               seen, d, bout, e.d, e.bout);
    end
    @(posedge clk); #1;
    start_op(8'h05, 8'h05, 1'b1);
    wait_done(n, bn, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || n != 9 || {d, bout} !== 9'h1FF || {d, bout, ovf} !== e) begin
      errors++;
      $display("[TB] FAIL b2b_second: seen=%b n=%0d got d=%h bout=%b want d=%h bout=%b at 9",
               seen, n, d, bout, e.d, e.bout);
    end
  endtask

  task automatic test_ignore_start;
    int pulses; logic [W-1:0] d_at_done; exp_t e;
    pulses = 0; d_at_done = '0;
    start_op(8'h35, 8'h12, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      if (n == 3) begin
        start = 1'b1; a = 8'hAA; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        d_at_done = d;
      end
      @(posedge clk); #1;
    end
    e = sb_q.pop_front();
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL ignore_pulses: got %0d done pulses want 1", pulses);
    end
    checks++;
    if (d_at_done !== e.d || d !== 8'h23) begin
      errors++;
      $display("[TB] FAIL ignore_result: got d=%h (at done %h) want %h", d, d_at_done, e.d);
    end
  endtask

  task automatic test_reset_abort;
    int n, bn, pulses; bit seen; exp_t e;
    start_op(8'h35, 8'h12, 1'b0);
    sb_q.delete();
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, d, bout} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL abort_outputs: busy=%b done=%b d=%h bout=%b want all 0",
               busy, done, d, bout);
    end
    pulses = 0;
    repeat (12) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %0d done pulses want 0", pulses);
    end
    start_op(8'h07, 8'h03, 1'b0);
    wait_done(n, bn, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || d !== 8'h04 || {d, bout, ovf} !== e) begin
      errors++;
      $display("[TB] FAIL abort_restart: seen=%b got d=%h bout=%b want d=%h bout=%b",
               seen, d, bout, e.d, e.bout);
    end
  endtask

  task automatic test_ovf;
    int n, bn; bit seen; exp_t e; logic want_ovf;
`ifdef SERIAL_SUB_OVF_EN
    want_ovf = 1'b1;
`else
    want_ovf = 1'b0;
`endif
    start_op(8'h80, 8'h01, 1'b0);
    wait_done(n, bn, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || {d, bout, ovf} !== {8'h7F, 1'b0, want_ovf} || {d, bout, ovf} !== e) begin
      errors++;
      $display("[TB] FAIL ovf_80_01: seen=%b got d=%h bout=%b ovf=%b want d=7f bout=0 ovf=%b",
               seen, d, bout, ovf, want_ovf);
    end
    @(posedge clk); #1;
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done(n, bn, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || {d, bout, ovf} !== {8'h7E, 1'b0, 1'b0} || {d, bout, ovf} !== e) begin
      errors++;
      $display("[TB] FAIL ovf_7f_01: seen=%b got d=%h bout=%b ovf=%b want d=7e bout=0 ovf=0",
               seen, d, bout, ovf);
    end
  endtask

  task automatic test_random;
    int n, bn; bit seen; exp_t e;
    logic [W-1:0] ra, rb; logic rbi;
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
      @(posedge clk); #1;
      start_op(ra, rb, rbi);
      wait_done(n, bn, seen);
      e = sb_q.pop_front();
      checks++;
      if (!seen || {d, bout, ovf} !== e) begin
        errors++;
        $display("[TB] FAIL random_%0d: a=%h b=%h bin=%b seen=%b got d=%h bout=%b ovf=%b want d=%h bout=%b ovf=%b",
                 i, ra, rb, rbi, seen, d, bout, ovf, e.d, e.bout, e.ovf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin_init = 1'b0;
    test_reset();
    test_basic();
    test_borrow_hold();
    test_back_to_back();
    @(posedge clk); #1;
    test_ignore_start();
    test_reset_abort();
    @(posedge clk); #1;
    test_ovf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction controller built around a single full-subtractor cell (x, y, borrow-in -> diff, borrow-out) and one borrow flop.
- Computes a WIDTH-bit difference d = a - b - bin_init, one bit per clock, LSB first.
- Used wherever multi-bit subtraction is needed without a parallel ripple subtractor.
- Sequences operand shifting, borrow propagation, result assembly and the start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; latched on accepted start.
- b  input  WIDTH  subtrahend; latched on accepted start.
- bin_init  input  1  initial borrow-in; latched on accepted start.
- busy  output  1  high while the operation is in progress (RUN and DONE).
- done  output  1  one-cycle pulse; d/bout/ovf valid from this cycle.
- d  output  WIDTH  difference.
- bout  output  1  final borrow-out (1 = a < b + bin_init, unsigned).
- ovf  output  1  signed overflow flag (see Optional Feature).

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- On reset, all state clears and outputs go to 0: busy, done, d, bout and ovf are 0. The state machine returns to IDLE.
- FSM states:
  - IDLE=2'b00:
    - start=1 latches a into shift register sa, b into sb, and bin_init into borrow flop br.
    - Bit counter cnt is cleared, the result register is cleared, and the FSM moves to RUN.
    - start=0 stays in IDLE.
  - RUN=2'b01:
    - Each cycle the cell evaluates x=sa[0], y=sb[0], br:
      - diff = x ^ y ^ br.
      - borrow = (~x & y) | (~(x ^ y) & br).
    - sa and sb shift right by 1.
    - diff shifts into the result register from the MSB side.
    - br <= borrow; cnt increments.
    - When cnt==WIDTH-1 (the last bit processed), the FSM moves to DONE.
  - DONE=2'b10:
    - done=1 for exactly this cycle.
    - d = result register, bout = br.
    - Next state is IDLE unconditionally.
  - 2'b11 is illegal and recovers to IDLE.
- Timing: start is accepted at edge T0.
  - busy is high from the cycle after T0 through the done cycle: WIDTH+1 cycles.
  - done is asserted in cycle T0+WIDTH+1.
  - Total latency is WIDTH+1 clocks.
- busy is low in IDLE, so a new start may be accepted in the cycle after done (back-to-back throughput is WIDTH+2 clocks).
- d, bout and ovf update only at the DONE transition and hold until the next DONE or reset; intermediate values never appear on them.
- start while busy=1 is ignored, with no queuing. a, b and bin_init may change freely after acceptance.
- Arithmetic is unsigned modulo 2^WIDTH: d = (a - b - bin_init) mod 2^WIDTH, bout = (a < b + bin_init).
- Reset asserted mid-RUN or in DONE aborts the operation:
  - Next cycle is IDLE with outputs 0.
  - No done pulse is produced.
  - Reset has priority over start in the same cycle.
- cnt width is clog2(WIDTH)+1 bits; no wrap occurs within an operation.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - At the last RUN cycle (cnt==WIDTH-1), the block captures ovf = (x ^ y) & (x ^ diff), using the operand sign bits and the result MSB.
  - ovf is registered at DONE and holds with d.
- Undefined:
  - ovf is tied to constant 0 and no capture logic is generated.
  - The port remains present so the interface is identical in both builds.

Test Plan:
- Reset, then WIDTH=8, a=8'h35, b=8'h12, bin_init=0, start for 1 cycle -> busy high 9 cycles; done pulse at T0+9; d=8'h23, bout=0.
- a=8'h00, b=8'h01, bin_init=0 -> d=8'hFF, bout=1; d holds 8'hFF for 5 idle cycles after done.
- a=8'h10, b=8'h0F, bin_init=1 -> d=8'h00, bout=0. Then immediately a=8'h05, b=8'h05, bin_init=1 -> d=8'hFF, bout=1.
- Start pulsed again with a=8'hAA, b=8'h01 at T0+3 during the op from scenario 1 -> ignored; result still 8'h23; only one done pulse.
- rst asserted at T0+4 mid-RUN -> next cycle busy=0, d=0, bout=0; no done. A fresh start afterwards with a=8'h07, b=8'h03 -> d=8'h04.
- a=8'h80, b=8'h01, bin_init=0 -> d=8'h7F, bout=0; ovf=1 with SERIAL_SUB_OVF_EN, ovf=0 without. Also a=8'h7F, b=8'h01 -> ovf=0 in both builds.
